// File: rtl/sampler_trigger.sv
// Trigger stage in front of the sampler: pipelines s_in, counts pattern matches and
// raises w_enable after an optional delay. Optional edge mode: SAMPLER_TRIGGER_EDGE_EN.
module sampler_trigger #(
    parameter int width     = 8,
    parameter int countBits = 16,
    parameter int delayBits = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [width-1:0]     s_in,
    output logic [width-1:0]     sample_out,
    output logic                 w_enable,
    input  logic                 arm,
    input  logic [width-1:0]     trig_mask,
    input  logic [width-1:0]     trig_value,
    input  logic                 trig_edge,
    input  logic [countBits-1:0] trig_count,
    input  logic [delayBits-1:0] trig_delay,
    output logic                 armed,
    output logic                 triggered
);

    typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [width-1:0]     q1;
    logic [width-1:0]     value_l;
    logic [width-1:0]     mask_l;
    logic [delayBits-1:0] delay_l;
    logic [delayBits-1:0] dly;
    logic [countBits-1:0] occ;
    logic                 level_hit;
    logic                 hit;

    assign level_hit = ((q1 ^ value_l) & mask_l) == '0;

`ifdef SAMPLER_TRIGGER_EDGE_EN
    logic [width-1:0] prev;
    logic             edge_l;

    // Edge mode: the previous sample must not have matched.
    assign hit = level_hit && (!edge_l || (((prev ^ value_l) & mask_l) != '0));
`else
    logic unused_trig_edge;

    assign unused_trig_edge = trig_edge;
    assign hit              = level_hit;
`endif

    always_comb begin
        state_nxt = state;
        if (!arm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ARMED;
                ARMED: if (hit && occ == countBits'(1))
                           state_nxt = (delay_l == '0) ? FIRED : DELAY;
                DELAY: if (dly == delayBits'(1)) state_nxt = FIRED;
                FIRED: state_nxt = FIRED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            q1         <= '0;
            sample_out <= '0;
            value_l    <= '0;
            mask_l     <= '0;
            delay_l    <= '0;
            dly        <= '0;
            occ        <= '0;
            armed      <= 1'b0;
            triggered  <= 1'b0;
`ifdef SAMPLER_TRIGGER_EDGE_EN
            prev       <= '0;
            edge_l     <= 1'b0;
`endif
        end else begin
            q1         <= s_in;
            sample_out <= q1;
`ifdef SAMPLER_TRIGGER_EDGE_EN
            prev       <= q1;
`endif
            state      <= state_nxt;
            // Outputs follow the next state so w_enable lines up with the matching sample.
            triggered  <= (state_nxt == FIRED);
            armed      <= (state_nxt == ARMED) || (state_nxt == DELAY);
            case (state)
                IDLE: if (arm) begin
                    value_l <= trig_value;
                    mask_l  <= trig_mask;
                    delay_l <= trig_delay;
                    occ     <= (trig_count == '0) ? countBits'(1) : trig_count;
`ifdef SAMPLER_TRIGGER_EDGE_EN
                    edge_l  <= trig_edge;
`endif
                end
                ARMED: if (arm && hit) begin
                    if (occ > countBits'(1)) occ <= occ - countBits'(1);
                    else if (delay_l != '0)  dly <= delay_l;
                end
                DELAY: if (arm && dly > delayBits'(1)) dly <= dly - delayBits'(1);
                default: ;
            endcase
        end
    end

    assign w_enable = triggered;

endmodule

// File: tb/tb_sampler_trigger.sv
// Directed self-checking bench for sampler_trigger; edge-mode expectations follow
// SAMPLER_TRIGGER_EDGE_EN when the build defines it.
module tb_sampler_trigger;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_in;
    logic [7:0]  sample_out;
    logic        w_enable;
    logic        arm;
    logic [7:0]  trig_mask;
    logic [7:0]  trig_value;
    logic        trig_edge;
    logic [15:0] trig_count;
    logic [15:0] trig_delay;
    logic        armed;
    logic        triggered;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sampler_trigger #(.width(8), .countBits(16), .delayBits(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_in       (s_in),
        .sample_out (sample_out),
        .w_enable   (w_enable),
        .arm        (arm),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .trig_count (trig_count),
        .trig_delay (trig_delay),
        .armed      (armed),
        .triggered  (triggered)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] m, input logic [7:0] v, input logic [15:0] c,
                       input logic [15:0] d, input logic e);
        trig_mask  = m;
        trig_value = v;
        trig_count = c;
        trig_delay = d;
        trig_edge  = e;
    endtask

    task automatic disarm;
        arm  = 1'b0;
        s_in = 8'h00;
        step;
        step;
    endtask

    // Drives a ramp from start until w_enable rises or the cycle budget expires.
    task automatic wait_fire(input logic [7:0] start, input int limit, output logic fired,
                             output logic [7:0] first, output logic armed_before,
                             output logic trig_at, output logic armed_at);
        fired = 1'b0; first = 8'h00; armed_before = 1'b0; trig_at = 1'b0; armed_at = 1'b0;
        for (int i = 0; i < limit && !fired; i++) begin
            armed_before = armed;
            s_in = start + 8'(i);
            step;
            if (w_enable) begin
                fired    = 1'b1;
                first    = sample_out;
                trig_at  = triggered;
                armed_at = armed;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; arm = 1'b0; s_in = 8'hC3;
        cfg(8'hFF, 8'h00, 16'd1, 16'd0, 1'b0);
        step; step;
        checks++; if (w_enable !== 1'b0) begin failures++; $display("FAIL reset_w_enable got=%b exp=0", w_enable); end
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL reset_triggered got=%b exp=0", triggered); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
        checks++; if (sample_out !== 8'h00) begin failures++; $display("FAIL reset_sample_out got=%h exp=00", sample_out); end
        reset_n = 1'b1; s_in = 8'h00;
        step; step;
    endtask

    task automatic test_level;
        logic f, ab, ta, aa; logic [7:0] fs;
        cfg(8'hFF, 8'h5A, 16'd1, 16'd0, 1'b0);
        arm = 1'b1; s_in = 8'h00;
        step;
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL level_armed_after_arm got=%b exp=1", armed); end
        // Config changes after arming must be ignored.
        trig_mask = 8'h00;
        wait_fire(8'h00, 300, f, fs, ab, ta, aa);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL level_fired got=%b exp=1", f); end
        checks++; if (fs !== 8'h5A) begin failures++; $display("FAIL level_first_sample got=%h exp=5a", fs); end
        checks++; if (ta !== 1'b1) begin failures++; $display("FAIL level_triggered got=%b exp=1", ta); end
        checks++; if (aa !== 1'b0) begin failures++; $display("FAIL level_armed_at_fire got=%b exp=0", aa); end
        step;
        checks++; if (w_enable !== 1'b1) begin failures++; $display("FAIL level_hold_fired got=%b exp=1", w_enable); end
        disarm;
        checks++; if (w_enable !== 1'b0 || armed !== 1'b0) begin failures++; $display("FAIL level_disarm got=%b%b exp=00", w_enable, armed); end
    endtask

    task automatic test_count;
        logic f, ab, ta, aa; logic [7:0] fs;
        cfg(8'hF0, 8'h10, 16'd3, 16'd0, 1'b0);
        arm = 1'b1; s_in = 8'h00;
        step;
        wait_fire(8'h00, 300, f, fs, ab, ta, aa);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL count_fired got=%b exp=1", f); end
        checks++; if (fs !== 8'h12) begin failures++; $display("FAIL count_first_sample got=%h exp=12", fs); end
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL count_armed_before got=%b exp=1", ab); end
        disarm;
    endtask

    task automatic test_delay;
        logic f, ab, ta, aa; logic [7:0] fs;
        cfg(8'hFF, 8'h5A, 16'd1, 16'd4, 1'b0);
        arm = 1'b1; s_in = 8'h00;
        step;
        wait_fire(8'h00, 300, f, fs, ab, ta, aa);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL delay_fired got=%b exp=1", f); end
        checks++; if (fs !== 8'h5E) begin failures++; $display("FAIL delay_first_sample got=%h exp=5e", fs); end
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL delay_armed_during got=%b exp=1", ab); end
        disarm;
    endtask

    task automatic test_edge;
        logic f, ab, ta, aa; logic [7:0] fs; logic exp_held;
`ifdef SAMPLER_TRIGGER_EDGE_EN
        exp_held = 1'b0;
`else
        exp_held = 1'b1;
`endif
        cfg(8'hFF, 8'h5A, 16'd1, 16'd0, 1'b1);
        s_in = 8'h5A;
        step; step;
        arm = 1'b1;
        for (int i = 0; i < 5; i++) step;
        checks++; if (w_enable !== exp_held) begin failures++; $display("FAIL edge_held got=%b exp=%b", w_enable, exp_held); end
        if (!exp_held) begin
            f = 1'b0; fs = 8'h00;
            for (int i = 0; i < 10 && !f; i++) begin
                s_in = (i % 2 == 0) ? 8'h00 : 8'h5A;
                step;
                if (w_enable) begin f = 1'b1; fs = sample_out; end
            end
            checks++; if (f !== 1'b1) begin failures++; $display("FAIL edge_fired got=%b exp=1", f); end
        end else begin
            fs = sample_out;
        end
        checks++; if (fs !== 8'h5A) begin failures++; $display("FAIL edge_sample got=%h exp=5a", fs); end
        disarm;
    endtask

    task automatic test_abort;
        cfg(8'hFF, 8'h5A, 16'd1, 16'd4, 1'b0);
        s_in = 8'h5A;
        step;
        arm = 1'b1;
        step; step;
        checks++; if (armed !== 1'b1 || w_enable !== 1'b0) begin failures++; $display("FAIL abort_in_delay got=%b%b exp=10", armed, w_enable); end
        arm = 1'b0;
        step;
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL abort_armed got=%b exp=0", armed); end
        for (int i = 0; i < 6; i++) begin
            step;
            checks++; if (w_enable !== 1'b0) begin failures++; $display("FAIL abort_w_enable got=%b exp=0", w_enable); end
        end
        cfg(8'hFF, 8'h5A, 16'd1, 16'd0, 1'b0);
        arm = 1'b1;
        step; step;
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL rst_pre_fired got=%b exp=1", triggered); end
        reset_n = 1'b0;
        step;
        checks++; if (w_enable !== 1'b0 || triggered !== 1'b0 || armed !== 1'b0 || sample_out !== 8'h00) begin
            failures++; $display("FAIL rst_in_fired got=%b%b%b/%h exp=000/00", w_enable, triggered, armed, sample_out);
        end
        reset_n = 1'b1;
        disarm;
    endtask

    task automatic test_mask_zero;
        logic f, ab, ta, aa; logic [7:0] fs;
        cfg(8'h00, 8'hA5, 16'd0, 16'd0, 1'b0);
        s_in = 8'h33;
        arm = 1'b1;
        step;
        checks++; if (armed !== 1'b1 || w_enable !== 1'b0) begin failures++; $display("FAIL mask0_first_armed got=%b%b exp=10", armed, w_enable); end
        step;
        checks++; if (w_enable !== 1'b1 || armed !== 1'b0) begin failures++; $display("FAIL mask0_fire got=%b%b exp=10", w_enable, armed); end
        disarm;
        cfg(8'hFF, 8'h20, 16'd0, 16'd0, 1'b0);
        arm = 1'b1;
        step;
        wait_fire(8'h00, 300, f, fs, ab, ta, aa);
        checks++; if (f !== 1'b1 || fs !== 8'h20) begin failures++; $display("FAIL count0_first_sample got=%b/%h exp=1/20", f, fs); end
        disarm;
    endtask

    initial begin
        test_reset;
        test_level;
        test_count;
        test_delay;
        test_edge;
        test_abort;
        test_mask_zero;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
